// File: rtl/sdram_scanout.sv
// Framebuffer scan-out: prefetches the next display line from SDRAM into a
// ping-pong line buffer while streaming the current line to the VGA pins.
module sdram_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned ADDR_W   = 25,
    parameter int unsigned FB_BASE  = 0
) (
    input  logic              MAIN_CLK,
    input  logic              RESET,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] dram_address,
    output logic              dram_read_n,
    input  logic              dram_waitreq,
    input  logic              dram_rdvalid,
    input  logic [15:0]       dram_readdata,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              underrun
);
    localparam int unsigned CNT_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned IDX_W = $clog2(H_ACTIVE);
    localparam int unsigned PIX_W = 12;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(H_ACTIVE);
    localparam logic [9:0]       X_LIMIT  = 10'(H_ACTIVE);
    localparam logic [9:0]       Y_FETCH  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [9:0]        drawy_q, drawy_d;
    logic [9:0]        target_q, target_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              read_n_q, read_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              underrun_q, underrun_d;
    logic              pix_vld_q, pix_vld_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;

    logic [PIX_W-1:0]  line_buf [2][H_ACTIVE];

    logic              trigger, tgt_valid, accept, ret_we, ret_done;
    logic [9:0]        tgt_line;
    logic              readdata_unused;

    // Line change detection and the line to prefetch for it
    assign trigger   = (DrawY != drawy_q) && !RESET;
    assign tgt_valid = (DrawY < Y_FETCH) || (DrawY == Y_LAST);
    assign tgt_line  = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
    assign accept    = (state_q == ISSUE) && !read_n_q && !dram_waitreq;
    assign ret_we    = dram_rdvalid && (state_q != IDLE) && (ret_cnt_q != CNT_FULL);
    assign ret_done  = (ret_cnt_q + CNT_W'(ret_we)) == CNT_FULL;
    assign readdata_unused = ^dram_readdata[15:PIX_W];

    always_ff @(posedge MAIN_CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trigger && tgt_valid) state_d = ISSUE;
            ISSUE:   if (accept && (issue_cnt_q == CNT_LAST)) state_d = DRAIN;
            DRAIN:   if (ret_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drawy_d     = DrawY;
        target_d    = target_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        underrun_d  = underrun_q;
        addr_d      = addr_q;
        if ((state_q == IDLE) && (state_d == ISSUE)) begin
            target_d    = tgt_line;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (accept) issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (ret_we) ret_cnt_d   = ret_cnt_q + CNT_W'(1);
        end
        if (trigger && (state_q != IDLE)) underrun_d = 1'b1;
        read_n_d = (state_d != ISSUE);
        // Address only advances on acceptance, so it stays put through a stall
        if (state_d == ISSUE)
            addr_d = ADDR_W'(FB_BASE) + ADDR_W'(target_d) * ADDR_W'(H_ACTIVE)
                   + ADDR_W'(issue_cnt_d);
        pix_vld_d = blank && (DrawX < X_LIMIT);
        pix_d     = line_buf[DrawY[0]][IDX_W'(DrawX)];
        rgb_d     = pix_vld_q ? pix_q : '0;
    end

    always_ff @(posedge MAIN_CLK) begin
        drawy_q <= drawy_d;
        if (RESET) begin
            target_q    <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            read_n_q    <= 1'b1;
            addr_q      <= '0;
            underrun_q  <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
            rgb_q       <= '0;
        end else begin
            target_q    <= target_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            read_n_q    <= read_n_d;
            addr_q      <= addr_d;
            underrun_q  <= underrun_d;
            pix_vld_q   <= pix_vld_d;
            pix_q       <= pix_d;
            rgb_q       <= rgb_d;
        end
    end

    // Returned words fill the bank selected by the target line's parity
    always_ff @(posedge MAIN_CLK) begin
        if (ret_we) line_buf[target_q[0]][IDX_W'(ret_cnt_q)] <= dram_readdata[PIX_W-1:0];
    end

    assign dram_address = addr_q;
    assign dram_read_n  = read_n_q;
    assign vga_r        = rgb_q[11:8];
    assign vga_g        = rgb_q[7:4];
    assign vga_b        = rgb_q[3:0];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_sdram_scanout.sv
// Bench for sdram_scanout: SDRAM model returning data = address, address and
// pixel scoreboards fed when stimulus is driven and drained as the DUT responds.
module tb_sdram_scanout;
    localparam int H = 640;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd523;
    logic        blank = 1'b0;
    logic [24:0] dram_address;
    logic        dram_read_n;
    logic        dram_waitreq = 1'b0;
    logic        dram_rdvalid = 1'b0;
    logic [15:0] dram_readdata = 16'd0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_scanout dut (
        .MAIN_CLK(clk), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .dram_address(dram_address), .dram_read_n(dram_read_n),
        .dram_waitreq(dram_waitreq), .dram_rdvalid(dram_rdvalid),
        .dram_readdata(dram_readdata),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // SDRAM model
    typedef struct { logic [24:0] a; int due; } pend_t;
    pend_t       pend[$];
    logic [24:0] acc_q[$];
    logic [24:0] exp_q[$];
    logic [24:0] hold_a[$];
    logic [24:0] hold_b[$];
    logic [11:0] px_q[$];
    int          lat = 3;
    bit          stall_mode = 1'b0;
    int          cyc = 0;
    bit          stalled_prev = 1'b0;
    logic [24:0] stalled_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pend_t p;
        dram_rdvalid  = 1'b0;
        dram_readdata = 16'd0;
        if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
            p = pend.pop_front();
            dram_rdvalid  = 1'b1;
            dram_readdata = p.a[15:0];
        end
        dram_waitreq = stall_mode && (cyc % 2 == 0);
        if (!RESET && !dram_read_n) begin
            if (stalled_prev) begin
                hold_a.push_back(stalled_addr);
                hold_b.push_back(dram_address);
            end
            if (dram_waitreq) begin
                stalled_prev = 1'b1;
                stalled_addr = dram_address;
            end else begin
                stalled_prev = 1'b0;
                acc_q.push_back(dram_address);
                p.a = dram_address;
                p.due = cyc + 1 + lat;
                pend.push_back(p);
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    function automatic logic [11:0] exp_pix(input int ln, input int x, input bit b);
        logic [24:0] a;
        if (!b || x >= H) return 12'h000;
        a = 25'(ln * H + x);
        return a[11:0];
    endfunction

    task automatic wait_quiet(output bit ok);
        int t = 0;
        while (pend.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        ok = (pend.size() == 0);
    endtask

    task automatic drain_fetch(output bit ok);
        int got = 0;
        int t = 0;
        while (got < H && t < 4000) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < H) begin
                void'(acc_q.pop_front());
                got++;
            end
        end
        wait_quiet(ok);
        ok = ok && (got == H);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dram_read_n !== 1'b1) begin n_bad++; $display("FAIL reset_read_n got %b want 1", dram_read_n); end
        n_cmp++; if (dram_address !== 25'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", dram_address); end
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_bad++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b}); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got %b want 0", underrun); end
        RESET = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (acc_q.size() != 0) begin n_bad++; $display("FAIL reset_no_reads got %0d want 0", acc_q.size()); end
    endtask

    task automatic test_basic_fetch();
        int got = 0;
        int t = 0;
        bit ok;
        logic [24:0] a, e;
        int xs0[5] = '{5, 0, 639, 300, 5};
        bit bs0[5] = '{1, 1, 1, 1, 0};
        int xs1[2] = '{5, 639};
        for (int i = 0; i < H; i++) exp_q.push_back(25'(i));
        DrawY = 10'd524;
        while (got < H && t < 3000) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < H) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); got++;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL basic_addr got %0d want %0d", a, e); end
            end
        end
        n_cmp++; if (got != H) begin n_bad++; $display("FAIL basic_count got %0d want %0d", got, H); end
        wait_quiet(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_returns pending %0d want 0", pend.size()); end
        n_cmp++; if (dram_read_n !== 1'b1) begin n_bad++; $display("FAIL basic_idle read_n %b want 1", dram_read_n); end
        n_cmp++; if (acc_q.size() != 0) begin n_bad++; $display("FAIL basic_extra got %0d want 0", acc_q.size()); end
        // Line 0 on screen while line 1 is fetched into the other bank
        DrawY = 10'd0;
        drain_fetch(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line1_fetch ok %b want 1", ok); end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e[11:0] = px_q.pop_front();
                n_cmp++; if ({vga_r, vga_g, vga_b} !== e[11:0]) begin n_bad++; $display("FAIL line0_pix got %h want %h", {vga_r, vga_g, vga_b}, e[11:0]); end
            end
            if (i < 5) begin DrawX = 10'(xs0[i]); blank = bs0[i]; px_q.push_back(exp_pix(0, xs0[i], bs0[i])); end
        end
        DrawY = 10'd1;
        drain_fetch(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line2_fetch ok %b want 1", ok); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e[11:0] = px_q.pop_front();
                n_cmp++; if ({vga_r, vga_g, vga_b} !== e[11:0]) begin n_bad++; $display("FAIL line1_pix got %h want %h", {vga_r, vga_g, vga_b}, e[11:0]); end
            end
            if (i < 2) begin DrawX = 10'(xs1[i]); blank = 1'b1; px_q.push_back(exp_pix(1, xs1[i], 1'b1)); end
        end
        blank = 1'b0;
    endtask

    task automatic test_stall();
        int got = 0;
        int t = 0;
        bit ok;
        logic [24:0] a, e;
        DrawY = 10'd9;
        drain_fetch(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line10_fetch ok %b want 1", ok); end
        hold_a.delete(); hold_b.delete();
        stall_mode = 1'b1;
        for (int i = 0; i < H; i++) exp_q.push_back(25'(7040 + i));
        DrawY = 10'd10;
        while (got < H && t < 4000) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < H) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); got++;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL stall_addr got %0d want %0d", a, e); end
            end
        end
        n_cmp++; if (got != H) begin n_bad++; $display("FAIL stall_count got %0d want %0d", got, H); end
        stall_mode = 1'b0;
        wait_quiet(ok);
        n_cmp++; if (hold_a.size() < 100) begin n_bad++; $display("FAIL stall_seen got %0d want >=100", hold_a.size()); end
        while (hold_a.size() != 0) begin
            a = hold_a.pop_front(); e = hold_b.pop_front();
            n_cmp++; if (e !== a) begin n_bad++; $display("FAIL stall_hold got %0d want %0d", e, a); end
        end
        n_cmp++; if (dram_read_n !== 1'b1 || acc_q.size() != 0) begin n_bad++; $display("FAIL stall_idle read_n %b extra %0d want 1/0", dram_read_n, acc_q.size()); end
    endtask

    task automatic test_blanking();
        logic [11:0] e;
        int xs[7] = '{5, 100, 640, 639, 639, 1023, 100};
        bit bs[7] = '{0, 1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = px_q.pop_front();
                n_cmp++; if ({vga_r, vga_g, vga_b} !== e) begin n_bad++; $display("FAIL blank_pix got %h want %h", {vga_r, vga_g, vga_b}, e); end
            end
            if (i < 7) begin DrawX = 10'(xs[i]); blank = bs[i]; px_q.push_back(exp_pix(10, xs[i], bs[i])); end
        end
        blank = 1'b0;
        for (int y = 479; y <= 523; y++) begin
            DrawY = 10'(y);
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (acc_q.size() != 0) begin n_bad++; $display("FAIL vblank_reads got %0d want 0", acc_q.size()); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL vblank_underrun got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        int got = 0;
        int t = 0;
        bit ok;
        logic [24:0] a, e;
        int xs[3] = '{0, 639, 320};
        lat = 2000;
        for (int i = 0; i < H; i++) exp_q.push_back(25'(64640 + i));
        DrawY = 10'd100;
        while (got < H && t < 1500) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < H) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); got++;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL urun_addr got %0d want %0d", a, e); end
            end
        end
        n_cmp++; if (got != H) begin n_bad++; $display("FAIL urun_count got %0d want %0d", got, H); end
        if (t < 1600) repeat (1600 - t) @(negedge clk);
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL urun_before got %b want 0", underrun); end
        DrawY = 10'd101;
        @(negedge clk);
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL urun_flag got %b want 1", underrun); end
        wait_quiet(ok);
        n_cmp++; if (!ok || acc_q.size() != 0) begin n_bad++; $display("FAIL urun_complete pending %0d extra %0d want 0/0", pend.size(), acc_q.size()); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL urun_sticky got %b want 1", underrun); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e[11:0] = px_q.pop_front();
                n_cmp++; if ({vga_r, vga_g, vga_b} !== e[11:0]) begin n_bad++; $display("FAIL urun_pix got %h want %h", {vga_r, vga_g, vga_b}, e[11:0]); end
            end
            if (i < 3) begin DrawX = 10'(xs[i]); blank = 1'b1; px_q.push_back(exp_pix(101, xs[i], 1'b1)); end
        end
        blank = 1'b0;
        lat = 3;
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int t = 0;
        bit ok;
        logic [24:0] a, e;
        int xs[2] = '{0, 639};
        for (int i = 0; i < H; i++) exp_q.push_back(25'(65920 + i));
        DrawX = 10'd5; blank = 1'b1;
        DrawY = 10'd102;
        while (got < 100 && t < 1000) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < 100) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); got++;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL mid_addr got %0d want %0d", a, e); end
            end
        end
        @(posedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        acc_q.delete(); exp_q.delete();
        @(negedge clk);
        n_cmp++; if (dram_read_n !== 1'b1) begin n_bad++; $display("FAIL mid_read_n got %b want 1", dram_read_n); end
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000 || underrun !== 1'b0 || dram_address !== 25'd0) begin
            n_bad++; $display("FAIL mid_outputs rgb %h urun %b addr %0d want 000/0/0", {vga_r, vga_g, vga_b}, underrun, dram_address);
        end
        RESET = 1'b0;
        blank = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (acc_q.size() != 0 || dram_read_n !== 1'b1) begin n_bad++; $display("FAIL mid_quiet reads %0d read_n %b want 0/1", acc_q.size(), dram_read_n); end
        got = 0; t = 0;
        for (int i = 0; i < H; i++) exp_q.push_back(25'(66560 + i));
        DrawY = 10'd103;
        while (got < H && t < 3000) begin
            @(negedge clk);
            t++;
            while (acc_q.size() != 0 && got < H) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); got++;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL restart_addr got %0d want %0d", a, e); end
            end
        end
        n_cmp++; if (got != H) begin n_bad++; $display("FAIL restart_count got %0d want %0d", got, H); end
        wait_quiet(ok);
        DrawY = 10'd104;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e[11:0] = px_q.pop_front();
                n_cmp++; if ({vga_r, vga_g, vga_b} !== e[11:0]) begin n_bad++; $display("FAIL restart_pix got %h want %h", {vga_r, vga_g, vga_b}, e[11:0]); end
            end
            if (i < 2) begin DrawX = 10'(xs[i]); blank = 1'b1; px_q.push_back(exp_pix(104, xs[i], 1'b1)); end
        end
        blank = 1'b0;
        drain_fetch(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line105_fetch ok %b want 1", ok); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_blanking();
        test_underrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
